// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
//   Shared types and helpers for the SPI-attached RAM controller.
//   - cmd_e        : 2-bit command prefix carried in the top bits of each received word
//   - state_e      : controller handshake state (IDLE accepts words, HOLD presents read data)
//   - addr_advance : address step with wrap from depth-1 back to 0
package spi_ram_pkg;

   localparam int unsigned CMD_W = 2;

   typedef enum logic [CMD_W-1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Next address after an access. The last real location wraps to 0; an
   // address already beyond the storage simply counts up and wraps at the
   // natural width of the address register.
   function automatic logic [31:0] addr_advance(input logic [31:0] addr,
                                                input int unsigned depth,
                                                input int unsigned addr_w);
      logic [31:0] mask;
      mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
      if (addr == depth - 32'd1) begin
         return '0;
      end
      return (addr + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem
//   MEM_DEPTH x DATA_W storage with one synchronous write port and one
//   synchronous (registered) read port. No reset; contents are undefined until
//   written. Callers must only enable a port for addresses below MEM_DEPTH.
//   Ports:
//     clk_i    clock
//     we_i     write enable, waddr_i / wdata_i written on the rising edge
//     re_i     read enable, rdata_o updated on the rising edge, held otherwise
//     raddr_i  read address
//     rdata_o  registered read data
module spi_ram_mem
   import spi_ram_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
//   Command-driven RAM slave sitting between an SPI deserialiser and on-chip
//   storage. Each received word is {cmd[1:0], payload[DATA_W-1:0]}:
//     00 set write address, 01 write data, 10 set read address, 11 read data.
//   A read moves the controller into HOLD, where dout/tx_valid stay stable and
//   no new words are accepted until the serialiser takes the data.
//   Optional feature macro: SPI_RAM_AUTOINC_EN -- when defined, the write
//   address advances after each data write and the read address after each
//   data read (wrapping MEM_DEPTH-1 -> 0).
//   Ports:
//     clk       clock, rising edge
//     rst       synchronous active-high reset
//     din       {cmd, payload} from deserialiser
//     rx_valid  din valid
//     rx_ready  controller accepts din (high exactly in IDLE)
//     dout      read data to serialiser
//     tx_valid  dout valid, held until tx_ready
//     tx_ready  serialiser accepts dout
//   Parameters: ADDR_W must not exceed DATA_W; 2 <= MEM_DEPTH <= 2**ADDR_W.
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   input  logic              tx_ready
);

   state_e            state_q;
   logic              rx_ready_q;
   logic              tx_valid_q;
   logic              rd_zero_q;   // current read word is forced to zero (reset or out of range)
   logic [ADDR_W-1:0] addr_wr_q;
   logic [ADDR_W-1:0] addr_rd_q;
   logic [ADDR_W-1:0] addr_wr_d;
   logic [ADDR_W-1:0] addr_rd_d;

   cmd_e              cmd;
   logic [DATA_W-1:0] payload;
   logic [ADDR_W-1:0] payload_addr;
   logic              accept;
   logic              wr_in_range;
   logic              rd_in_range;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   assign cmd          = cmd_e'(din[DATA_W+1:DATA_W]);
   assign payload      = din[DATA_W-1:0];
   assign payload_addr = din[ADDR_W-1:0];

   // rx_ready is registered and only ever high in IDLE, so acceptance needs no
   // extra state qualification and there is no path from tx_ready/rx_valid.
   assign accept      = rx_valid && rx_ready_q;
   assign wr_in_range = (32'(addr_wr_q) < MEM_DEPTH);
   assign rd_in_range = (32'(addr_rd_q) < MEM_DEPTH);
   assign mem_we      = accept && (cmd == CMD_WR_DATA) && wr_in_range;
   assign mem_re      = accept && (cmd == CMD_RD_DATA) && rd_in_range;

`ifdef SPI_RAM_AUTOINC_EN
   assign addr_wr_d = ADDR_W'(addr_advance(32'(addr_wr_q), MEM_DEPTH, ADDR_W));
   assign addr_rd_d = ADDR_W'(addr_advance(32'(addr_rd_q), MEM_DEPTH, ADDR_W));
`else
   assign addr_wr_d = addr_wr_q;
   assign addr_rd_d = addr_rd_q;
`endif

   spi_ram_mem #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (mem_we),
      .waddr_i (addr_wr_q),
      .wdata_i (payload),
      .re_i    (mem_re),
      .raddr_i (addr_rd_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rx_ready_q <= 1'b1;
         tx_valid_q <= 1'b0;
         rd_zero_q  <= 1'b1;
         addr_wr_q  <= '0;
         addr_rd_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  case (cmd)
                     CMD_WR_ADDR: addr_wr_q <= payload_addr;
                     CMD_WR_DATA: addr_wr_q <= addr_wr_d;
                     CMD_RD_ADDR: addr_rd_q <= payload_addr;
                     CMD_RD_DATA: begin
                        addr_rd_q  <= addr_rd_d;
                        rd_zero_q  <= !rd_in_range;
                        tx_valid_q <= 1'b1;
                        rx_ready_q <= 1'b0;
                        state_q    <= ST_HOLD;
                     end
                  endcase
               end
            end
            ST_HOLD: begin
               if (tx_ready) begin
                  tx_valid_q <= 1'b0;
                  rx_ready_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end
            end
         endcase
      end
   end

   // The memory read register only updates on an in-range read, so it holds
   // through HOLD; out-of-range reads and the post-reset value are masked to 0.
   assign dout     = rd_zero_q ? '0 : mem_rdata;
   assign rx_ready = rx_ready_q;
   assign tx_valid = tx_valid_q;

endmodule
